// File: rtl/common_types_pkg.sv
// Shared types for the branch-predictor update path.
//   word_t           : 32-bit machine word
//   branch_pred_t    : 2-bit saturating counter encoding
//   btb_ctrl_state_t : update sequencer states
//   btb_upd_t        : one queued table write {index, taken, target}
// The index field is sized for the largest supported table (BTB_BITS <= BTB_IDX_W);
// users truncate it to their own table width.
package common_types_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned BTB_IDX_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      STRONG_NOT_TAKEN = 2'd0,
      WEAK_NOT_TAKEN   = 2'd1,
      WEAK_TAKEN       = 2'd2,
      STRONG_TAKEN     = 2'd3
   } branch_pred_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } btb_ctrl_state_t;

   typedef struct packed {
      logic [BTB_IDX_W-1:0] index;
      logic                 taken;
      word_t                target;
   } btb_upd_t;

   // Table index of a word-aligned PC: pc[bits+1:2], zero-extended.
   function automatic logic [BTB_IDX_W-1:0] pc_to_index(input word_t pc, input int unsigned bits);
      word_t mask;
      mask = (word_t'(1) << bits) - word_t'(1);
      return BTB_IDX_W'((pc >> 2) & mask);
   endfunction

endpackage

// File: rtl/btb_update_ctrl_if.sv
// Bus between the update sequencer, the memory stage, fetch and the predictor write port.
//   master : the sequencer (drives upd_*, predict_en, inval_busy, q_ovf)
//   slave  : the surrounding pipeline / predictor (drives mem_*, inval_req, upd_ready)
interface btb_update_ctrl_if #(
   parameter int unsigned BTB_BITS = 8
);
   import common_types_pkg::*;

   logic                mem_branch;
   word_t               mem_pc;
   logic                mem_taken;
   word_t               mem_target_res;
   logic                inval_req;

   logic                upd_valid;
   logic                upd_ready;
   logic [BTB_BITS-1:0] upd_index;
   logic                upd_taken;
   word_t               upd_target;
   logic                upd_clear;

   logic                predict_en;
   logic                inval_busy;
   logic                q_ovf;

   modport master (
      input  mem_branch, mem_pc, mem_taken, mem_target_res, inval_req, upd_ready,
      output upd_valid, upd_index, upd_taken, upd_target, upd_clear,
             predict_en, inval_busy, q_ovf
   );

   modport slave (
      output mem_branch, mem_pc, mem_taken, mem_target_res, inval_req, upd_ready,
      input  upd_valid, upd_index, upd_taken, upd_target, upd_clear,
             predict_en, inval_busy, q_ovf
   );

endinterface

// File: rtl/btb_upd_fifo.sv
// In-order FIFO of pending predictor updates.
//   clk, nrst    : clock, async active-low reset
//   flush_i      : discard all entries (wins over push/pop)
//   push_i/data_i: enqueue one entry
//   pop_i        : dequeue the head (caller guarantees non-empty)
//   full_o       : all DEPTH entries occupied
//   empty_nxt_o  : FIFO will be empty after this edge
//   head_nxt_o   : head entry after this edge (valid when !empty_nxt_o)
// Pointers carry one extra wrap bit to tell full from empty.
module btb_upd_fifo
   import common_types_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic     clk,
   input  logic     nrst,
   input  logic     flush_i,
   input  logic     push_i,
   input  logic     pop_i,
   input  btb_upd_t data_i,
   output logic     full_o,
   output logic     empty_nxt_o,
   output btb_upd_t head_nxt_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW = AW + 1;

   btb_upd_t      mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;

   assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // Pointer next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   assign empty_nxt_o = (wr_ptr_d == rd_ptr_d);

   // Look-ahead head: an entry pushed into an (effectively) empty FIFO becomes head at once.
   always_comb begin
      head_nxt_o = mem_q[rd_ptr_d[AW-1:0]];
      if (push_i && (rd_ptr_d == wr_ptr_q)) head_nxt_o = data_i;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is datapath only; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/btb_update_ctrl.sv
// Sequencer for the branch predictor's single write port (counter + target tables).
// Queues resolved-branch updates, runs a full-table invalidation sweep on request
// (sweep has priority), and gates fetch-side prediction while the tables are cleared.
//   clk, nrst : clock, async active-low reset
//   bus       : btb_update_ctrl_if.master (mem_* updates in, upd_* write port out,
//               inval_req in, predict_en / inval_busy / q_ovf status out)
// Parameters: BTB_BITS (log2 table entries, <= BTB_IDX_W), QUEUE_DEPTH (power of two, >= 2).
// Optional macro BTB_UPD_BYPASS_EN: an update arriving in IDLE with the FIFO empty is
// presented on the write port in the same cycle and skips the FIFO if accepted.
module btb_update_ctrl
   import common_types_pkg::*;
#(
   parameter int unsigned BTB_BITS    = 8,
   parameter int unsigned QUEUE_DEPTH = 4
) (
   input  logic clk,
   input  logic nrst,
   btb_update_ctrl_if.master bus
);

   localparam logic [1:0]          ST_IDLE  = 2'(IDLE);
   localparam logic [1:0]          ST_SWEEP = 2'(SWEEP);
   localparam logic [1:0]          ST_DONE  = 2'(DONE);
   localparam logic [BTB_BITS-1:0] IDX_LAST = '1;

   logic [1:0]          state_q, state_d;
   logic [BTB_BITS-1:0] idx_q, idx_d;

   logic                upd_valid_q, upd_valid_d;
   logic                upd_clear_q, upd_clear_d;
   logic [BTB_BITS-1:0] upd_index_q, upd_index_d;
   logic                upd_taken_q, upd_taken_d;
   word_t               upd_target_q, upd_target_d;
   logic                predict_en_q, predict_en_d;
   logic                inval_busy_q, inval_busy_d;
   logic                q_ovf_q, q_ovf_d;

   logic                in_idle;
   logic                upd_arrive;
   logic                byp_taken;
   logic                push, pop;
   logic                fifo_full, fifo_empty_nxt;
   btb_upd_t            new_upd, head_nxt;

   assign in_idle = (state_q == ST_IDLE);

   assign new_upd = '{index:  pc_to_index(bus.mem_pc, BTB_BITS),
                      taken:  bus.mem_taken,
                      target: bus.mem_target_res};

   // Updates are only accepted in IDLE and never alongside an invalidation.
   assign upd_arrive = in_idle && bus.mem_branch && !bus.inval_req;

   // In IDLE upd_valid_q tracks FIFO non-empty, so this is a head write accepted.
   assign pop  = in_idle && upd_valid_q && bus.upd_ready;
   assign push = upd_arrive && !byp_taken && (!fifo_full || pop);

   btb_upd_fifo #(
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .nrst        (nrst),
      .flush_i     (bus.inval_req),
      .push_i      (push),
      .pop_i       (pop),
      .data_i      (new_upd),
      .full_o      (fifo_full),
      .empty_nxt_o (fifo_empty_nxt),
      .head_nxt_o  (head_nxt)
   );

   // State register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         upd_valid_q  <= 1'b0;
         upd_clear_q  <= 1'b0;
         upd_index_q  <= '0;
         upd_taken_q  <= 1'b0;
         upd_target_q <= '0;
         predict_en_q <= 1'b1;
         inval_busy_q <= 1'b0;
         q_ovf_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         upd_valid_q  <= upd_valid_d;
         upd_clear_q  <= upd_clear_d;
         upd_index_q  <= upd_index_d;
         upd_taken_q  <= upd_taken_d;
         upd_target_q <= upd_target_d;
         predict_en_q <= predict_en_d;
         inval_busy_q <= inval_busy_d;
         q_ovf_q      <= q_ovf_d;
      end
   end

   // Next state and next registered outputs
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      upd_valid_d  = 1'b0;
      upd_clear_d  = 1'b0;
      upd_index_d  = '0;
      upd_taken_d  = 1'b0;
      upd_target_d = '0;

      case (state_q)
         ST_IDLE: ;
         ST_SWEEP: begin
            if (bus.upd_ready) begin
               if (idx_q == IDX_LAST) state_d = ST_DONE;
               else                   idx_d   = idx_q + BTB_BITS'(1);
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Invalidation (re)starts the sweep from any state.
      if (bus.inval_req) begin
         state_d = ST_SWEEP;
         idx_d   = '0;
      end

      case (state_d)
         ST_SWEEP: begin
            upd_valid_d = 1'b1;
            upd_clear_d = 1'b1;
            upd_index_d = idx_d;
         end
         ST_IDLE: begin
            if (!fifo_empty_nxt) begin
               upd_valid_d  = 1'b1;
               upd_index_d  = BTB_BITS'(head_nxt.index);
               upd_taken_d  = head_nxt.taken;
               upd_target_d = head_nxt.target;
            end
         end
         default: ;
      endcase

      predict_en_d = (state_d == ST_IDLE);
      inval_busy_d = (state_d != ST_IDLE);
      q_ovf_d      = upd_arrive && fifo_full && !pop;
   end

`ifdef BTB_UPD_BYPASS_EN
   logic byp_hit;

   // FIFO empty in IDLE <=> no registered command pending.
   assign byp_hit   = upd_arrive && !upd_valid_q;
   assign byp_taken = byp_hit && bus.upd_ready;

   assign bus.upd_valid  = upd_valid_q | byp_hit;
   assign bus.upd_clear  = upd_clear_q;
   assign bus.upd_index  = byp_hit ? BTB_BITS'(new_upd.index) : upd_index_q;
   assign bus.upd_taken  = byp_hit ? new_upd.taken             : upd_taken_q;
   assign bus.upd_target = byp_hit ? new_upd.target            : upd_target_q;
`else
   assign byp_taken = 1'b0;

   assign bus.upd_valid  = upd_valid_q;
   assign bus.upd_clear  = upd_clear_q;
   assign bus.upd_index  = upd_index_q;
   assign bus.upd_taken  = upd_taken_q;
   assign bus.upd_target = upd_target_q;
`endif

   assign bus.predict_en = predict_en_q;
   assign bus.inval_busy = inval_busy_q;
   assign bus.q_ovf      = q_ovf_q;

endmodule
